// File: rtl/flop_delay_pipe_if.sv
// Bundle of the control, data and status signals of flop_delay_pipe.
//   master : driver side (en, flush, in_valid, in_data, delay_sel out; status in)
//   slave  : pipe side (controls and input beat in; out_valid, out_data, occupancy, sel_err out)
interface flop_delay_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) ();
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] delay_sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] occupancy;
  logic             sel_err;

  modport master (
    output en, flush, in_valid, in_data, delay_sel,
    input  out_valid, out_data, occupancy, sel_err
  );

  modport slave (
    input  en, flush, in_valid, in_data, delay_sel,
    output out_valid, out_data, occupancy, sel_err
  );
endinterface

// File: rtl/flop_delay_pipe.sv
// Run-time selectable delay line: DEPTH flop stages of {valid, WIDTH data}.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   bus.en       : advance the whole chain; 0 holds every stage
//   bus.flush    : invalidate every stage (data held)
//   bus.in_*     : beat entering stage 0 on advance
//   bus.delay_sel: tap select 1..DEPTH; illegal values clamp to DEPTH and raise sel_err
//   bus.out_*    : selected tap, data forced to 0 when not valid
//   bus.occupancy: valid beats anywhere in the chain
module flop_delay_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                rst,
  flop_delay_pipe_if.slave   bus
);

  localparam logic [SEL_W-1:0] MaxSel = SEL_W'(DEPTH);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [SEL_W-1:0] occ_q, occ_d;

  logic             sel_err;
  logic [SEL_W-1:0] tap_sel;
  logic             tap_vld;
  logic [WIDTH-1:0] tap_dat;

  // Priority below rst: flush, then advance, else hold.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    occ_d = occ_q;
    if (bus.flush) begin
      vld_d = '0;
      occ_d = '0;
    end else if (bus.en) begin
      vld_d[0] = bus.in_valid;
      dat_d[0] = bus.in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
      // Last stage drops out as the new beat enters, so the count stays within 0..DEPTH.
      occ_d = occ_q + SEL_W'(bus.in_valid) - SEL_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  // Tap mux: delay_sel counts from 1, so stage k sits behind select value k+1.
  always_comb begin
    sel_err = (bus.delay_sel == '0) || (bus.delay_sel > MaxSel);
    tap_sel = sel_err ? MaxSel : bus.delay_sel;
    tap_vld = 1'b0;
    tap_dat = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (tap_sel == SEL_W'(k + 1)) begin
        tap_vld = vld_q[k];
        tap_dat = dat_q[k];
      end
    end
  end

  assign bus.out_valid = tap_vld;
  assign bus.out_data  = tap_vld ? tap_dat : '0;
  assign bus.occupancy = occ_q;
  assign bus.sel_err   = sel_err;

endmodule

// File: tb/tb_flop_delay_pipe.sv
module tb_flop_delay_pipe;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flop_delay_pipe_if #(.WIDTH(32), .DEPTH(16)) bus ();
  flop_delay_pipe_if #(.WIDTH(32), .DEPTH(1))  bus1 ();

  flop_delay_pipe #(.WIDTH(32), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flop_delay_pipe #(.WIDTH(32), .DEPTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Scoreboard: each accepted beat knows when it reaches the tap and when it leaves the chain.
  typedef struct {
    int          tap_due;
    int          end_due;
    logic [31:0] data;
  } beat_t;
  beat_t sb[$];

  logic        ev;
  logic [31:0] ed;
  int          eo;

  function automatic int eff_sel(input logic [4:0] s);
    return (s == 5'd0 || s > 5'd16) ? 16 : int'(s);
  endfunction

  function automatic void sb_expect(input int c);
    ev = 1'b0;
    ed = '0;
    eo = sb.size();
    foreach (sb[i]) begin
      if (sb[i].tap_due == c) begin
        ev = 1'b1;
        ed = sb[i].data;
      end
    end
  endfunction

  // Apply this cycle's inputs to the model after the outputs have been compared.
  function automatic void sb_update(input int c);
    beat_t b;
    if (rst || bus.flush) begin
      sb.delete();
    end else if (!bus.en) begin
      foreach (sb[i]) begin
        sb[i].tap_due = sb[i].tap_due + 1;
        sb[i].end_due = sb[i].end_due + 1;
      end
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].end_due == c) sb.delete(i);
      end
      if (bus.in_valid) begin
        b.tap_due = c + eff_sel(bus.delay_sel);
        b.end_due = c + 16;
        b.data    = bus.in_data;
        sb.push_back(b);
      end
    end
  endfunction

  task automatic drive(input logic r, input logic e, input logic f, input logic v,
                       input logic [31:0] d, input logic [4:0] s);
    @(negedge clk);
    rst           = r;
    bus.en        = e;
    bus.flush     = f;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.delay_sel = s;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive((i < 3), 1'b1, 1'b0, (i < 3), 32'hA5A5_0000 + i, 5'd4);
      if (i > 0) begin
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.occupancy !== 5'd0) begin
          n_err++;
          $display("FAIL reset cyc%0d: got v=%b d=%h occ=%0d, want 0/0/0", i, bus.out_valid,
                   bus.out_data, bus.occupancy);
        end
        n_cmp++;
        if (bus1.out_valid !== 1'b0 || bus1.occupancy !== 1'b0) begin
          n_err++;
          $display("FAIL reset_d1 cyc%0d: got v=%b occ=%0d, want 0/0", i, bus1.out_valid,
                   bus1.occupancy);
        end
      end
      sb_update(cyc);
    end
  endtask

  // Shared per-cycle stimulus table runner with inline compares is repeated in each test.
  task automatic test_basic();
    logic [31:0] dat [3] = '{32'h11, 32'h22, 32'h33};
    int peak = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd4);
    sb_update(cyc);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i < 3), (i < 3) ? dat[i] : 32'd0, 5'd4);
      sb_expect(cyc);
      n_cmp++;
      if (bus.out_valid !== ev || bus.out_data !== ed) begin
        n_err++;
        $display("FAIL basic_out cyc%0d: got v=%b d=%h, want v=%b d=%h", i, bus.out_valid,
                 bus.out_data, ev, ed);
      end
      n_cmp++;
      if (int'(bus.occupancy) !== eo) begin
        n_err++;
        $display("FAIL basic_occ cyc%0d: got %0d, want %0d", i, bus.occupancy, eo);
      end
      if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
      sb_update(cyc);
    end
    n_cmp++;
    if (peak !== 3) begin
      n_err++;
      $display("FAIL basic_peak: got %0d, want 3", peak);
    end
  endtask

  task automatic test_stall();
    int seen11 = -1;
    int seen22 = -1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd4);
    sb_update(cyc);
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, !(i >= 2 && i <= 4), 1'b0, (i < 3),
            (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : 32'd0, 5'd4);
      sb_expect(cyc);
      n_cmp++;
      if (bus.out_valid !== ev || bus.out_data !== ed || int'(bus.occupancy) !== eo) begin
        n_err++;
        $display("FAIL stall cyc%0d: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d", i,
                 bus.out_valid, bus.out_data, bus.occupancy, ev, ed, eo);
      end
      if (bus.out_valid && bus.out_data == 32'h11) seen11 = i;
      if (bus.out_valid && bus.out_data == 32'h22) seen22 = i;
      n_cmp++;
      if (bus.out_valid === 1'b1 && bus.out_data === 32'h33) begin
        n_err++;
        $display("FAIL stall_lost cyc%0d: got d=33, want beat dropped", i);
      end
      sb_update(cyc);
    end
    n_cmp++;
    if (seen11 !== 7 || seen22 !== 8) begin
      n_err++;
      $display("FAIL stall_timing: got 11@%0d 22@%0d, want 11@7 22@8", seen11, seen22);
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd8);
    sb_update(cyc);
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, 1'b1, (i == 5), (i <= 5), (i == 5) ? 32'hDEAD : 32'h40 + i, 5'd8);
      sb_expect(cyc);
      n_cmp++;
      if (bus.out_valid !== ev || bus.out_data !== ed || int'(bus.occupancy) !== eo) begin
        n_err++;
        $display("FAIL flush cyc%0d: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d", i,
                 bus.out_valid, bus.out_data, bus.occupancy, ev, ed, eo);
      end
      if (i == 6) begin
        n_cmp++;
        if (bus.occupancy !== 5'd0 || bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL flush_clear: got occ=%0d v=%b, want 0/0", bus.occupancy, bus.out_valid);
        end
      end
      sb_update(cyc);
    end
  endtask

  task automatic test_sel_err();
    logic [4:0] sels [3] = '{5'd0, 5'd17, 5'd16};
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, sels[t]);
      sb_update(cyc);
      for (int i = 0; i < 18; i++) begin
        drive(1'b0, 1'b1, 1'b0, (i == 0), 32'hC0 + t, sels[t]);
        sb_expect(cyc);
        n_cmp++;
        if (bus.sel_err !== (t < 2)) begin
          n_err++;
          $display("FAIL sel_err sel=%0d: got %b, want %b", sels[t], bus.sel_err, (t < 2));
        end
        n_cmp++;
        if (bus.out_valid !== ev || bus.out_data !== ed) begin
          n_err++;
          $display("FAIL sel_tap sel=%0d cyc%0d: got v=%b d=%h, want v=%b d=%h", sels[t], i,
                   bus.out_valid, bus.out_data, ev, ed);
        end
        sb_update(cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd16);
    sb_update(cyc);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i < 20), (i < 20) ? i : 32'd0, 5'd16);
      sb_expect(cyc);
      n_cmp++;
      if (bus.out_valid !== ev || bus.out_data !== ed || int'(bus.occupancy) !== eo) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d", i,
                 bus.out_valid, bus.out_data, bus.occupancy, ev, ed, eo);
      end
      if (i >= 16 && i <= 20) begin
        n_cmp++;
        if (bus.occupancy !== 5'd16) begin
          n_err++;
          $display("FAIL b2b_sat cyc%0d: got %0d, want 16", i, bus.occupancy);
        end
      end
      sb_update(cyc);
    end
  endtask

  task automatic test_depth1();
    logic        pv = 1'b0;
    logic [31:0] pd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus1.en        = 1'b1;
      bus1.flush     = 1'b0;
      bus1.in_valid  = (i != 3) && (i < 6);
      bus1.in_data   = 32'h100 + i;
      bus1.delay_sel = 1'b1;
      #1;
      n_cmp++;
      if (bus1.out_valid !== pv || bus1.out_data !== (pv ? pd : 32'd0) ||
          bus1.occupancy !== pv || bus1.sel_err !== 1'b0) begin
        n_err++;
        $display("FAIL depth1 cyc%0d: got v=%b d=%h occ=%0d err=%b, want v=%b d=%h occ=%0d err=0",
                 i, bus1.out_valid, bus1.out_data, bus1.occupancy, bus1.sel_err, pv,
                 pv ? pd : 32'd0, pv);
      end
      pv = bus1.in_valid;
      pd = bus1.in_data;
    end
    @(negedge clk);
    bus1.en        = 1'b0;
    bus1.delay_sel = 1'b0;
    #1;
    n_cmp++;
    if (bus1.sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL depth1_sel0: got %b, want 1", bus1.sel_err);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.delay_sel  = 5'd4;
    bus1.en        = 1'b0;
    bus1.flush     = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.delay_sel = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_sel_err();
    test_back_to_back();
    test_depth1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
